// File: rtl/gpr_cdb_arbiter_pkg.sv
// Shared types for the GPR common data bus: bus payload and tag helpers.
package gpr_cdb_arbiter_pkg;

    localparam int unsigned ROB_WIDTH = 5;
    localparam int unsigned DATA_W    = 32;

    // One CDB beat; execution units reuse the same layout for their result register.
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [DATA_W-1:0]    data;
    } cdb_t;

    // True when a valid bus beat carries the tag a consumer is waiting on.
    function automatic logic tag_match(input cdb_t bus, input logic [ROB_WIDTH-1:0] tag);
        return bus.valid && (bus.tag == tag);
    endfunction

endpackage

// File: rtl/req_if.sv
// Per-unit request handshake: the unit raises valid, the arbiter answers with ready.
interface req_if;
    logic valid;
    logic ready;

    modport requester (output valid, input ready);
    modport responder (input valid, output ready);
endinterface

// File: rtl/gpr_cdb_arbiter_rr_pick.sv
// Round-robin priority search: first set request at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk N_REQ slots starting at ptr; the first requester found wins.
    always_comb begin
        logic [IDX_W-1:0] slot;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        slot = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            slot = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!any && req[slot]) begin
                any       = 1'b1;
                gnt[slot] = 1'b1;
                idx       = slot;
            end
        end
    end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// GPR CDB arbiter: grants one execution unit per cycle (round-robin) and broadcasts
// the granted unit's result on the cycle after the dispatch edge.
module gpr_cdb_arbiter
    import gpr_cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic            clk,
    input  logic            reset,
    req_if.responder        req [N_REQ-1:0],
    input  cdb_t            unit_result [N_REQ-1:0],
    output cdb_t            gpr_cdb
);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_masked;
    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] ptr_d;

    logic [IDX_W-1:0] ptr_q;
    logic             grant_v_q;
    logic [IDX_W-1:0] grant_idx_q;

    // Units only supply tag/data; their valid bit carries no meaning here.
    logic [N_REQ-1:0] unused_result_valid;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign req_valid[g]           = req[g].valid;
        assign req[g].ready           = pick_gnt[g];
        assign unused_result_valid[g] = unit_result[g].valid;
    end

    // Hide all requests during reset so no ready (and hence no dispatch) can appear.
    always_comb begin
        req_masked = reset ? '0 : req_valid;
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req_masked),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next search start is the slot just after the winner, wrapping at N_REQ-1.
    always_comb begin
        if (pick_idx == IDX_W'(N_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = pick_idx + IDX_W'(1);
        end
    end

    // Dispatch bookkeeping; ready is only ever set on a valid line, so any == dispatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_v_q   <= 1'b0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else if (pick_any) begin
            grant_v_q   <= 1'b1;
            grant_idx_q <= pick_idx;
            ptr_q       <= ptr_d;
        end else begin
            grant_v_q   <= 1'b0;
        end
    end

    // Broadcast straight from the granted unit's result register in the cycle after dispatch.
    always_comb begin
        gpr_cdb       = '0;
        gpr_cdb.valid = grant_v_q;
        gpr_cdb.tag   = unit_result[grant_idx_q].tag;
        gpr_cdb.data  = unit_result[grant_idx_q].data;
    end

endmodule
